// File: rtl/cvt12n_cfu.sv
// CFU-L2 initiator to N fixed-latency CFU-L1 targets: tag pipeline plus in-order response queue.
// Optional: define CVT12N_CFU_BAD_CFU_EN to return CFU_ERROR_CFU for out-of-range req_cfu.
module cvt12n_cfu #(
  parameter int CFU_N_TARGETS  = 2,
  parameter int CFU_LATENCY    = 0,
  parameter int CFU_QUEUE_SIZE = (CFU_LATENCY > 1) ? CFU_LATENCY : 1,
  parameter int CFU_CFU_ID_W   = 4,
  parameter int CFU_STATE_ID_W = 1,
  parameter int CFU_FUNC_ID_W  = 10,
  parameter int CFU_DATA_W     = 32,
  parameter int CFU_STATUS_W   = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clk_en,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [CFU_CFU_ID_W-1:0]               req_cfu,
  input  logic [CFU_STATE_ID_W-1:0]             req_state,
  input  logic [CFU_FUNC_ID_W-1:0]              req_func,
  input  logic [31:0]                           req_insn,
  input  logic [CFU_DATA_W-1:0]                 req_data0,
  input  logic [CFU_DATA_W-1:0]                 req_data1,
  output logic                                  resp_valid,
  input  logic                                  resp_ready,
  output logic [CFU_STATUS_W-1:0]               resp_status,
  output logic [CFU_DATA_W-1:0]                 resp_data,
  output logic [CFU_N_TARGETS-1:0]              t_req_valid,
  output logic [CFU_STATE_ID_W-1:0]             t_req_state,
  output logic [CFU_FUNC_ID_W-1:0]              t_req_func,
  output logic [CFU_DATA_W-1:0]                 t_req_data0,
  output logic [CFU_DATA_W-1:0]                 t_req_data1,
  input  logic [CFU_N_TARGETS-1:0]              t_resp_valid,
  input  logic [CFU_N_TARGETS*CFU_STATUS_W-1:0] t_resp_status,
  input  logic [CFU_N_TARGETS*CFU_DATA_W-1:0]   t_resp_data
);
  localparam int TW = (CFU_N_TARGETS > 1) ? $clog2(CFU_N_TARGETS) : 1;
  localparam int QW = (CFU_QUEUE_SIZE > 1) ? $clog2(CFU_QUEUE_SIZE) : 1;
  localparam int QD = 2 ** QW;
  localparam int CW = $clog2(CFU_QUEUE_SIZE + 1);
`ifdef CVT12N_CFU_BAD_CFU_EN
  localparam logic [CFU_STATUS_W-1:0] CFU_ERROR_CFU = CFU_STATUS_W'(1);
`endif

  typedef struct packed {
    logic          vld;
    logic          err;
    logic [TW-1:0] tgt;
  } tag_t;

  typedef struct packed {
    logic [CFU_STATUS_W-1:0] status;
    logic [CFU_DATA_W-1:0]   data;
  } rsp_t;

  logic          req_hs, resp_hs, bad_cfu, enq;
  logic [CW-1:0] count_q, count_d, fill_q, fill_d;
  logic [QW-1:0] wr_ptr_q, rd_ptr_q;
  tag_t          tag_in, tag_out;
  rsp_t          enq_ent;
  rsp_t          mem_q [QD];

  // Instruction word and target valids carry no routing information here.
  logic unused_in;
  assign unused_in = ^{req_insn, t_resp_valid};

  assign bad_cfu   = int'(req_cfu) >= CFU_N_TARGETS;
  assign req_ready = clk_en && !rst && (count_q < CW'(CFU_QUEUE_SIZE));
  assign req_hs    = req_valid && req_ready;
  assign resp_hs   = resp_valid && resp_ready;

  assign t_req_state = req_state;
  assign t_req_func  = req_func;
  assign t_req_data0 = req_data0;
  assign t_req_data1 = req_data1;

  always_comb begin
    t_req_valid = '0;
    for (int i = 0; i < CFU_N_TARGETS; i++)
      if (req_hs && !bad_cfu && req_cfu == CFU_CFU_ID_W'(i)) t_req_valid[i] = 1'b1;
  end

  always_comb begin
    tag_in     = '0;
    tag_in.vld = req_hs;
    tag_in.err = bad_cfu;
    tag_in.tgt = req_cfu[TW-1:0];
  end

  generate
    if (CFU_LATENCY == 0) begin : g_nopipe
      assign tag_out = tag_in;
    end else begin : g_pipe
      tag_t pipe_q [CFU_LATENCY];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < CFU_LATENCY; s++) pipe_q[s] <= '0;
        end else if (clk_en) begin
          pipe_q[0] <= tag_in;
          for (int s = 1; s < CFU_LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
        end
      end
      assign tag_out = pipe_q[CFU_LATENCY-1];
    end
  endgenerate

  // Capture the addressed target's response as the tag leaves the pipeline.
  always_comb begin
    enq_ent = '0;
    for (int i = 0; i < CFU_N_TARGETS; i++) begin
      if (tag_out.tgt == TW'(i)) begin
        enq_ent.status = t_resp_status[i*CFU_STATUS_W +: CFU_STATUS_W];
        enq_ent.data   = t_resp_data[i*CFU_DATA_W +: CFU_DATA_W];
      end
    end
    if (tag_out.err) begin
`ifdef CVT12N_CFU_BAD_CFU_EN
      enq_ent.status = CFU_ERROR_CFU;
`else
      enq_ent.status = '0;
`endif
      enq_ent.data = '0;
    end
  end

  assign enq = tag_out.vld;

  function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
    return (p == QW'(CFU_QUEUE_SIZE - 1)) ? '0 : p + QW'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    fill_d  = fill_q;
    if (req_hs && !resp_hs) count_d = count_q + CW'(1);
    else if (!req_hs && resp_hs) count_d = count_q - CW'(1);
    if (enq && !resp_hs) fill_d = fill_q + CW'(1);
    else if (!enq && resp_hs) fill_d = fill_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clk_en) begin
      count_q <= count_d;
      fill_q  <= fill_d;
      if (enq)     wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (resp_hs) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && enq) mem_q[wr_ptr_q] <= enq_ent;
  end

  assign resp_valid  = (fill_q != '0);
  assign resp_status = mem_q[rd_ptr_q].status;
  assign resp_data   = mem_q[rd_ptr_q].data;
endmodule

// File: tb/tb_cvt12n_cfu.sv
// Random-stimulus bench for cvt12n_cfu: a LAT=2 and a LAT=0 instance checked against a transaction-level model.
module tb_cvt12n_cfu;
  localparam int N = 2;
  localparam int Q = 2;
  localparam int NCYC = 3000;
  localparam int RST_CYC = 1600;
`ifdef CVT12N_CFU_BAD_CFU_EN
  localparam logic [2:0] BAD_ST = 3'd1;
`else
  localparam logic [2:0] BAD_ST = 3'd0;
`endif

  logic        clk = 1'b0;
  logic        rst, clk_en, req_valid, resp_ready;
  logic [3:0]  req_cfu;
  logic [0:0]  req_state;
  logic [9:0]  req_func;
  logic [31:0] req_insn, d0, d1;
  logic [1:0]  t_rv;
  logic [5:0]  t_rs;
  logic [63:0] t_rd;

  logic [1:0]        rdy, rvld;
  logic [1:0][2:0]   rsts;
  logic [1:0][31:0]  rdat, td0, td1;
  logic [1:0][1:0]   tv;
  logic [1:0][0:0]   tst;
  logic [1:0][9:0]   tfn;

  always #5 clk = ~clk;

  cvt12n_cfu #(.CFU_N_TARGETS(N), .CFU_LATENCY(2), .CFU_QUEUE_SIZE(Q)) u_dut_l2 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(rdy[0]), .req_cfu(req_cfu), .req_state(req_state),
    .req_func(req_func), .req_insn(req_insn), .req_data0(d0), .req_data1(d1),
    .resp_valid(rvld[0]), .resp_ready(resp_ready), .resp_status(rsts[0]), .resp_data(rdat[0]),
    .t_req_valid(tv[0]), .t_req_state(tst[0]), .t_req_func(tfn[0]),
    .t_req_data0(td0[0]), .t_req_data1(td1[0]),
    .t_resp_valid(t_rv), .t_resp_status(t_rs), .t_resp_data(t_rd)
  );

  cvt12n_cfu #(.CFU_N_TARGETS(N), .CFU_LATENCY(0), .CFU_QUEUE_SIZE(Q)) u_dut_l0 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(rdy[1]), .req_cfu(req_cfu), .req_state(req_state),
    .req_func(req_func), .req_insn(req_insn), .req_data0(d0), .req_data1(d1),
    .resp_valid(rvld[1]), .resp_ready(resp_ready), .resp_status(rsts[1]), .resp_data(rdat[1]),
    .t_req_valid(tv[1]), .t_req_state(tst[1]), .t_req_func(tfn[1]),
    .t_req_data0(td0[1]), .t_req_data1(td1[1]),
    .t_resp_valid(t_rv), .t_resp_status(t_rs), .t_resp_data(t_rd)
  );

  int n_chk = 0;
  int n_fail = 0;
  int ecyc = 0;
  // Outstanding-request list per instance: enabled cycle of acceptance and requested cfu.
  int ent_cyc [2][64];
  int ent_cfu [2][64];
  int head [2];
  int tail [2];
  // Target response values seen at each enabled cycle.
  logic [2:0]  log_s [4096][2];
  logic [31:0] log_d [4096][2];

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (ecyc %0d)", tag, act, exp, ecyc);
    end
  endtask

  initial begin
    int ph, cnt, hc, hf;
    logic er, erv;
    logic [1:0] etv;
    logic [2:0] es;
    logic [31:0] ed;
    rst = 1'b1; clk_en = 1'b0; req_valid = 1'b1; resp_ready = 1'b1;
    req_cfu = '0; req_state = '0; req_func = '0; req_insn = '0; d0 = '0; d1 = '0;
    t_rv = '0; t_rs = '0; t_rd = '0;
    head[0] = 0; head[1] = 0; tail[0] = 0; tail[1] = 0;
    @(negedge clk);
    clk_en = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_rvld%0d", d), 64'(rvld[d]), 64'd0);
      chk($sformatf("reset_rdy%0d", d), 64'(rdy[d]), 64'd0);
      chk($sformatf("reset_tv%0d", d), 64'(tv[d]), 64'd0);
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc == RST_CYC) begin
        // Asynchronous reset while requests are in flight: outputs must drop at once.
        rst = 1'b1; clk_en = 1'b1; req_valid = 1'b1; req_cfu = 4'd0;
        #1;
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("midrst_rvld%0d", d), 64'(rvld[d]), 64'd0);
          chk($sformatf("midrst_rdy%0d", d), 64'(rdy[d]), 64'd0);
          chk($sformatf("midrst_tv%0d", d), 64'(tv[d]), 64'd0);
          head[d] = 0;
          tail[d] = 0;
        end
        continue;
      end
      rst = 1'b0;
      ph = (cyc / 250) % 3;
      clk_en     = (ph == 2) ? ($urandom_range(0, 9) != 0) : 1'b1;
      req_valid  = (ph == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      resp_ready = (ph == 0) ? 1'b1 : (ph == 1) ? 1'($urandom_range(0, 1))
                                                : ($urandom_range(0, 9) == 0);
      req_cfu    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15))
                                               : 4'($urandom_range(0, 1));
      d0 = $urandom; d1 = $urandom; req_insn = $urandom;
      req_func = 10'($urandom); req_state = 1'($urandom);
      t_rv = 2'($urandom); t_rs = 6'($urandom); t_rd = {$urandom, $urandom};
      #1;
      log_s[ecyc % 4096][0] = t_rs[2:0];
      log_s[ecyc % 4096][1] = t_rs[5:3];
      log_d[ecyc % 4096][0] = t_rd[31:0];
      log_d[ecyc % 4096][1] = t_rd[63:32];
      for (int d = 0; d < 2; d++) begin
        cnt = tail[d] - head[d];
        er  = clk_en && (cnt < Q);
        etv = (req_valid && er && req_cfu < 4'(N)) ? (2'b01 << req_cfu) : 2'b00;
        erv = (cnt > 0) && (ent_cyc[d][head[d] % 64] + lat(d) + 1 <= ecyc);
        chk($sformatf("req_ready%0d", d), 64'(rdy[d]), 64'(er));
        chk($sformatf("t_req_valid%0d", d), 64'(tv[d]), 64'(etv));
        chk($sformatf("t_req_data0_%0d", d), 64'(td0[d]), 64'(d0));
        chk($sformatf("t_req_func%0d", d), 64'(tfn[d]), 64'(req_func));
        chk($sformatf("resp_valid%0d", d), 64'(rvld[d]), 64'(erv));
        if (erv) begin
          hc = ent_cyc[d][head[d] % 64];
          hf = ent_cfu[d][head[d] % 64];
          if (hf >= N) begin
            es = BAD_ST;
            ed = '0;
          end else begin
            es = log_s[(hc + lat(d)) % 4096][hf];
            ed = log_d[(hc + lat(d)) % 4096][hf];
          end
          chk($sformatf("resp_status%0d", d), 64'(rsts[d]), 64'(es));
          chk($sformatf("resp_data%0d", d), 64'(rdat[d]), 64'(ed));
        end
        if (clk_en) begin
          if (erv && resp_ready) head[d]++;
          if (req_valid && er) begin
            ent_cyc[d][tail[d] % 64] = ecyc;
            ent_cfu[d][tail[d] % 64] = int'(req_cfu);
            tail[d]++;
          end
        end
      end
      if (clk_en) ecyc++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
